// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and parity helper for the PS/2 key decoder.
package ps2_pkg;

    // Tracked scan codes and prefix bytes
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_L     = 8'h4B;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw pins, finds clock falls, shifts in
// 11-bit frames, checks start/parity/stop and discards stalled frames.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned TIMEOUT_US  = 2000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_clk,
    input  logic       key_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       good_byte,
    output logic [7:0] good_data
);

    localparam int unsigned TIMEOUT_CYC = (CLK_HZ / 32'd1000000) * TIMEOUT_US;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 32'd1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    ps2_state_e             state_q, state_d;
    logic [10:0]            shift_q, shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic [7:0]             code_q, code_d;
    logic                   code_valid_q, code_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   fall_s;
    logic                   data_s;
    logic                   frame_ok_s;

    // Synchroniser shift and edge-detect history (bus idles high)
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], key_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], key_data};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        fall_s      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        data_s      = data_sync_q[SYNC_STAGES-1];
        frame_ok_s  = ~shift_q[0] & shift_q[10] & odd_parity_ok(shift_q[8:1], shift_q[9]);
    end

    // Frame FSM: shift on falls, watch for stalls, validate the finished frame
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = tmo_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        good_byte    = 1'b0;
        good_data    = shift_q[8:1];
        case (state_q)
            IDLE: begin
                tmo_d = {CNT_W{1'b0}};
                if (fall_s && !data_s) begin
                    shift_d   = {data_s, 10'd0};
                    bit_cnt_d = 4'd1;
                    state_d   = RECV;
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (fall_s) begin
                    shift_d = {data_s, shift_q[10:1]};
                    tmo_d   = {CNT_W{1'b0}};
                    if (bit_cnt_q == 4'd10) begin
                        bit_cnt_d = 4'd0;
                        state_d   = CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = 4'd0;
                    tmo_d       = {CNT_W{1'b0}};
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_ok_s) begin
                    code_valid_d = 1'b1;
                    code_d       = shift_q[8:1];
                    good_byte    = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q   <= {SYNC_STAGES{1'b1}};
            data_sync_q  <= {SYNC_STAGES{1'b1}};
            clk_prev_q   <= 1'b1;
            state_q      <= IDLE;
            shift_q      <= 11'd0;
            bit_cnt_q    <= 4'd0;
            tmo_q        <= {CNT_W{1'b0}};
            code_q       <= 8'd0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: frame receiver plus make/break/extended prefix
// tracking and one held-level bit for each of the lane keys A, S, K, L.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned TIMEOUT_US  = 2000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_clk,
    input  logic       key_data,
    output logic       a,
    output logic       s,
    output logic       k,
    output logic       l,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       frame_err
);

    logic       good_byte_s;
    logic [7:0] good_data_s;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       a_q, a_d, s_q, s_d, k_q, k_d, l_q, l_d;

    ps2_rx_frame #(
        .CLK_HZ      (CLK_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst),
        .key_clk    (key_clk),
        .key_data   (key_data),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .good_byte  (good_byte_s),
        .good_data  (good_data_s)
    );

    // Prefix flags and key levels advance only on a validated byte; the
    // register lands in the same cycle as the receiver's code_valid
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        a_d   = a_q;
        s_d   = s_q;
        k_d   = k_q;
        l_d   = l_q;
        if (good_byte_s) begin
            case (good_data_s)
                SC_EXT:   ext_d = 1'b1;
                SC_BREAK: brk_d = 1'b1;
                default: begin
                    // Extended codes share base codes with tracked keys; skip them
                    if (!ext_q) begin
                        case (good_data_s)
                            SC_A:    a_d = ~brk_q;
                            SC_S:    s_d = ~brk_q;
                            SC_K:    k_d = ~brk_q;
                            SC_L:    l_d = ~brk_q;
                            default: a_d = a_q;
                        endcase
                    end else begin
                        a_d = a_q;
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end else begin
            ext_d = ext_q;
        end
    end

    // Prefix and key-level registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            a_q   <= 1'b0;
            s_q   <= 1'b0;
            k_q   <= 1'b0;
            l_q   <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
            a_q   <= a_d;
            s_q   <= s_d;
            k_q   <= k_d;
            l_q   <= l_d;
        end
    end

    assign a = a_q;
    assign s = s_q;
    assign k = k_q;
    assign l = l_q;

endmodule
